// File: rtl/ttl_read_request_sync_if.sv
// TTL read-path bus bundle: TTL strobes/address/data plus the request/response
// handshake toward the AXI read master. slave = the sync block, master = its environment.
interface ttl_read_request_sync_if #(
  parameter int C_ADDR_WIDTH = 16,
  parameter int C_DATA_WIDTH = 8
);
  logic                    chipEnable;
  logic                    outputEnable;
  logic [C_ADDR_WIDTH-1:0] address;
  logic [C_DATA_WIDTH-1:0] data;
  logic                    dataDrive;
  logic                    reqValid;
  logic                    reqReady;
  logic [C_ADDR_WIDTH-1:0] reqAddress;
  logic                    rspValid;
  logic [C_DATA_WIDTH-1:0] rspData;
  logic                    timeoutError;

  modport slave (
    input  chipEnable, outputEnable, address, reqReady, rspValid, rspData,
    output data, dataDrive, reqValid, reqAddress, timeoutError
  );

  modport master (
    output chipEnable, outputEnable, address, reqReady, rspValid, rspData,
    input  data, dataDrive, reqValid, reqAddress, timeoutError
  );
endinterface

// File: rtl/ttl_read_request_sync.sv
// Synchronises asynchronous TTL read strobes/address into ACLK, issues one read request per
// stable access and drives the returned data back. Optional single-entry cache: TTL_READ_CACHE_EN.
module ttl_read_request_sync #(
  parameter int C_ADDR_WIDTH     = 16,
  parameter int C_DATA_WIDTH     = 8,
  parameter int C_SYNC_STAGES    = 2,
  parameter int C_STABLE_CYCLES  = 2,
  parameter int C_TIMEOUT_CYCLES = 255
) (
  input logic                    ACLK,
  input logic                    ARESETN,
  ttl_read_request_sync_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETTLE   = 3'd1;
  localparam logic [2:0] S_REQUEST  = 3'd2;
  localparam logic [2:0] S_WAIT_RSP = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  localparam int             STW          = (C_STABLE_CYCLES > 1) ? $clog2(C_STABLE_CYCLES) : 1;
  localparam logic [STW-1:0] STABLE_LAST  = STW'(C_STABLE_CYCLES - 1);
  localparam logic [7:0]     TIMEOUT_LAST = 8'(C_TIMEOUT_CYCLES - 1);

  logic [C_SYNC_STAGES-1:0]                   ce_sync;
  logic [C_SYNC_STAGES-1:0]                   oe_sync;
  logic [C_SYNC_STAGES-1:0][C_ADDR_WIDTH-1:0] addr_sync;

  logic                    access;
  logic [C_ADDR_WIDTH-1:0] addr_s;

  logic [2:0]              state;
  logic [C_ADDR_WIDTH-1:0] cap_addr;
  logic [C_ADDR_WIDTH-1:0] req_addr;
  logic [STW-1:0]          stable_cnt;
  logic [7:0]              timer;
  logic                    abort;
  logic [C_DATA_WIDTH-1:0] data_q;
  logic                    timeout_err;
`ifdef TTL_READ_CACHE_EN
  logic                    cache_valid;
  logic [C_ADDR_WIDTH-1:0] cache_addr;
  logic [C_DATA_WIDTH-1:0] cache_data;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ce_sync   <= '0;
      oe_sync   <= '0;
      addr_sync <= '0;
    end else begin
      ce_sync[0]   <= bus.chipEnable;
      oe_sync[0]   <= bus.outputEnable;
      addr_sync[0] <= bus.address;
      for (int unsigned i = 1; i < C_SYNC_STAGES; i++) begin
        ce_sync[i]   <= ce_sync[i-1];
        oe_sync[i]   <= oe_sync[i-1];
        addr_sync[i] <= addr_sync[i-1];
      end
    end
  end

  assign access = ce_sync[C_SYNC_STAGES-1] & oe_sync[C_SYNC_STAGES-1];
  assign addr_s = addr_sync[C_SYNC_STAGES-1];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= S_IDLE;
      cap_addr    <= '0;
      req_addr    <= '0;
      stable_cnt  <= '0;
      timer       <= '0;
      abort       <= 1'b0;
      data_q      <= '0;
      timeout_err <= 1'b0;
`ifdef TTL_READ_CACHE_EN
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          abort <= 1'b0;
          if (access) begin
            cap_addr   <= addr_s;
            stable_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!access) begin
            state <= S_IDLE;
          end else if (addr_s != cap_addr) begin
            cap_addr   <= addr_s;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
`ifdef TTL_READ_CACHE_EN
            if (cache_valid && (cache_addr == cap_addr)) begin
              data_q <= cache_data;
              state  <= S_HOLD;
            end else begin
              req_addr <= cap_addr;
              state    <= S_REQUEST;
            end
`else
            req_addr <= cap_addr;
            state    <= S_REQUEST;
`endif
          end else begin
            stable_cnt <= stable_cnt + STW'(1);
          end
        end
        // Once raised the request is never withdrawn; a dropped strobe only marks the access aborted.
        S_REQUEST: begin
          if (!access) abort <= 1'b1;
          if (bus.reqReady) begin
            timer <= '0;
            state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (!access) abort <= 1'b1;
          if (bus.rspValid) begin
            data_q <= bus.rspData;
`ifdef TTL_READ_CACHE_EN
            cache_valid <= 1'b1;
            cache_addr  <= req_addr;
            cache_data  <= bus.rspData;
`endif
            state <= (abort || !access) ? S_IDLE : S_HOLD;
          end else if (timer == TIMEOUT_LAST) begin
            data_q      <= '1;
            timeout_err <= 1'b1;
`ifdef TTL_READ_CACHE_EN
            cache_valid <= 1'b0;
`endif
            state <= (abort || !access) ? S_IDLE : S_HOLD;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        // Address moved under a held strobe: treat it as a fresh access without going through IDLE.
        S_HOLD: begin
          if (!access) begin
            state <= S_IDLE;
          end else if (addr_s != cap_addr) begin
            cap_addr   <= addr_s;
            stable_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.reqValid     = (state == S_REQUEST);
  assign bus.reqAddress   = req_addr;
  assign bus.dataDrive    = (state == S_HOLD);
  assign bus.data         = data_q;
  assign bus.timeoutError = timeout_err;

endmodule

// File: tb/tb_ttl_read_request_sync.sv
// Directed bench for ttl_read_request_sync with a request/data scoreboard checked by monitors.
`timescale 1ns/1ps
module tb_ttl_read_request_sync;

`ifdef TTL_READ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] exp_req[$];
  logic [7:0]  exp_data[$];

  ttl_read_request_sync_if #(.C_ADDR_WIDTH(16), .C_DATA_WIDTH(8)) bus ();

  ttl_read_request_sync #(
    .C_ADDR_WIDTH    (16),
    .C_DATA_WIDTH    (8),
    .C_SYNC_STAGES   (2),
    .C_STABLE_CYCLES (2),
    .C_TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK   (clk),
    .ARESETN(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request monitor: every accepted request must match the next expected address.
  always @(negedge clk) begin
    if (rst_n && bus.reqValid && bus.reqReady) begin
      if (exp_req.size() == 0) fail("unexp_req", $sformatf("request at 0x%0h, none expected", bus.reqAddress));
      else check("req_addr", 32'(bus.reqAddress), 32'(exp_req.pop_front()));
    end
  end

  // Data monitor: each rising dataDrive must present the next expected data.
  logic drive_q = 1'b0;
  always @(negedge clk) begin
    if (bus.dataDrive && !drive_q) begin
      if (exp_data.size() == 0) fail("unexp_drive", $sformatf("dataDrive with 0x%0h, none expected", bus.data));
      else check("drive_data", 32'(bus.data), 32'(exp_data.pop_front()));
    end
    drive_q = bus.dataDrive;
  end

  task automatic wait_handshake(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.reqValid && bus.reqReady) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drive(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.dataDrive) ok = 1'b1;
    end
    #1;
  endtask

  task automatic pulse_rsp(input int delay, input logic [7:0] v);
    if (delay > 1) cyc(delay - 1);
    bus.rspValid = 1'b1;
    bus.rspData  = v;
    cyc(1);
    bus.rspValid = 1'b0;
  endtask

  task automatic release_strobes();
    bus.chipEnable   = 1'b0;
    bus.outputEnable = 1'b0;
    cyc(6);
  endtask

  task automatic read_access(input string name, input logic [15:0] addr, input logic [7:0] rdata,
                             input bit expect_req, input int delay);
    bit ok;
    bus.address      = addr;
    bus.chipEnable   = 1'b1;
    bus.outputEnable = 1'b1;
    exp_data.push_back(rdata);
    if (expect_req) begin
      exp_req.push_back(addr);
      wait_handshake(ok);
      if (!ok) fail({name, "_hs"}, "no request handshake within bound");
      else pulse_rsp(delay, rdata);
    end
    wait_drive(ok);
    if (!ok) fail({name, "_drive"}, "dataDrive never asserted");
    cyc(3);
    check({name, "_hold_drive"}, 32'(bus.dataDrive), 32'd1);
    check({name, "_hold_data"}, 32'(bus.data), 32'(rdata));
    release_strobes();
    check({name, "_released"}, 32'(bus.dataDrive), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bad;
    rst_n            = 1'b0;
    bus.chipEnable   = 1'b0;
    bus.outputEnable = 1'b0;
    bus.address      = '0;
    bus.reqReady     = 1'b1;
    bus.rspValid     = 1'b0;
    bus.rspData      = '0;
    cyc(3);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_drive", 32'(bus.dataDrive), 32'd0);
    check("rst_reqvalid", 32'(bus.reqValid), 32'd0);
    check("rst_reqaddr", 32'(bus.reqAddress), 32'd0);
    check("rst_timeout", 32'(bus.timeoutError), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // 1: basic read
    read_access("t1", 16'h1234, 8'h5A, 1'b1, 3);

    // 2: address toggling must not issue a request until it settles
    bus.chipEnable   = 1'b1;
    bus.outputEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.address = (i % 2 == 1) ? 16'h0011 : 16'h0010;
      cyc(1);
    end
    read_access("t2", 16'h0011, 8'h77, 1'b1, 2);

    // 3: reqReady held low, strobe drops mid-request
    bus.reqReady     = 1'b0;
    bus.address      = 16'h0300;
    bus.chipEnable   = 1'b1;
    bus.outputEnable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc(1);
      if (bus.reqValid) ok = 1'b1;
    end
    if (!ok) fail("t3_req", "reqValid never asserted");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bus.chipEnable = 1'b0;
      cyc(1);
      if (!bus.reqValid || bus.reqAddress != 16'h0300) bad++;
    end
    check("t3_req_held", 32'(bad), 32'd0);
    exp_req.push_back(16'h0300);
    bus.reqReady = 1'b1;
    wait_handshake(ok);
    if (!ok) fail("t3_hs", "no request handshake within bound");
    pulse_rsp(2, 8'h44);
    cyc(8);
    check("t3_no_drive", 32'(bus.dataDrive), 32'd0);
    release_strobes();

    // 4: response timeout after 8 cycles, sticky error, late response ignored
    exp_req.push_back(16'h0404);
    exp_data.push_back(8'hFF);
    bus.address      = 16'h0404;
    bus.chipEnable   = 1'b1;
    bus.outputEnable = 1'b1;
    wait_handshake(ok);
    if (!ok) fail("t4_hs", "no request handshake within bound");
    cyc(7);
    check("t4_pre_drive", 32'(bus.dataDrive), 32'd0);
    check("t4_pre_err", 32'(bus.timeoutError), 32'd0);
    cyc(1);
    check("t4_drive", 32'(bus.dataDrive), 32'd1);
    check("t4_err", 32'(bus.timeoutError), 32'd1);
    pulse_rsp(1, 8'h12);
    cyc(2);
    check("t4_late_rsp", 32'(bus.data), 32'hFF);
    release_strobes();
    check("t4_sticky", 32'(bus.timeoutError), 32'd1);
    check("t4_released", 32'(bus.dataDrive), 32'd0);

    // 5: asynchronous reset during WAIT_RSP
    exp_req.push_back(16'h0505);
    bus.address      = 16'h0505;
    bus.chipEnable   = 1'b1;
    bus.outputEnable = 1'b1;
    wait_handshake(ok);
    if (!ok) fail("t5_hs", "no request handshake within bound");
    cyc(2);
    rst_n = 1'b0;
    #2;
    check("t5_data", 32'(bus.data), 32'd0);
    check("t5_drive", 32'(bus.dataDrive), 32'd0);
    check("t5_reqvalid", 32'(bus.reqValid), 32'd0);
    check("t5_reqaddr", 32'(bus.reqAddress), 32'd0);
    check("t5_timeout", 32'(bus.timeoutError), 32'd0);
    bus.chipEnable   = 1'b0;
    bus.outputEnable = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    read_access("t5_after", 16'h0606, 8'h66, 1'b1, 2);

    // 6: repeated address (cached when the cache is built in), then a new address
    read_access("t6_first", 16'h0200, 8'h33, 1'b1, 2);
    read_access("t6_second", 16'h0200, 8'h33, !CACHE, 2);
    read_access("t6_other", 16'h0201, 8'h21, 1'b1, 2);

    cyc(5);
    check("left_req", 32'(exp_req.size()), 32'd0);
    check("left_data", 32'(exp_data.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
